// File: rtl/regfile.sv
// regfile: single-port scratch store of DATA_D words of DATA_W bits.
// Writes commit on the rising edge of clk; reads are combinational from addr.
// Addresses at or above DATA_D are not backed by storage: writes there are
// dropped (no wrap onto lower words) and reads return zero.
// DATA_D must not exceed 2**ADDR_W.
module regfile #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DATA_D = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] indata,
    output logic [DATA_W-1:0] outdata
);

    localparam logic [31:0] DEPTH = DATA_D;

    logic [DATA_W-1:0] mem_q [DATA_D];
    logic [DATA_W-1:0] mem_d [DATA_D];
    logic              addr_ok;

    assign addr_ok = (32'(addr) < DEPTH);

    // Next-state storage: copy of current contents with the addressed word replaced on a legal write
    always_comb begin
        mem_d = mem_q;
        if (we && addr_ok) begin
            mem_d[addr] = indata;
        end
    end

    // Storage update; reset clears every word and wins over a same-edge write
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Asynchronous read; unbacked addresses read as zero
    always_comb begin
        outdata = '0;
        if (addr_ok) begin
            outdata = mem_q[addr];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a default 32-word instance and a 20-word
// instance for the unbacked-address behaviour.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] indata;
    logic [31:0] outdata;

    logic        we20;
    logic [4:0]  addr20;
    logic [31:0] indata20;
    logic [31:0] outdata20;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile #(.ADDR_W(5), .DATA_W(32), .DATA_D(32)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .addr    (addr),
        .indata  (indata),
        .outdata (outdata)
    );

    regfile #(.ADDR_W(5), .DATA_W(32), .DATA_D(20)) u_dut20 (
        .clk     (clk),
        .reset   (reset),
        .we      (we20),
        .addr    (addr20),
        .indata  (indata20),
        .outdata (outdata20)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; indata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, outdata, exp);
    endtask

    task automatic rd20(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr20 = a;
        #1;
        check(tag, outdata20, exp);
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; addr = '0; indata = '0;
        we20 = 1'b0; addr20 = '0; indata20 = '0;
        tick();
        reset = 1'b0;

        // state straight after the first reset edge
        rd("rst_a0", 5'd0, 32'h0);
        rd("rst_a31", 5'd31, 32'h0);

        // reset clear
        wr(5'd3, 32'hA5A5A5A5);
        rd("pre_clr_a3", 5'd3, 32'hA5A5A5A5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd("clr_a0", 5'd0, 32'h0);
        rd("clr_a3", 5'd3, 32'h0);
        rd("clr_a31", 5'd31, 32'h0);

        // full sweep: write i, next cycle read back with we low and indata zeroed
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), 32'(i));
            indata = '0;
            addr = 5'(i);
            tick();
            check($sformatf("sweep_%0d", i), outdata, 32'(i));
        end

        // write-disabled hold
        wr(5'd7, 32'h12345678);
        we = 1'b0; addr = 5'd7; indata = 32'hFFFFFFFF;
        #1;
        check("hold_now", outdata, 32'h12345678);
        tick();
        check("hold_edge", outdata, 32'h12345678);

        // write visible right after the edge while addr still selects it
        we = 1'b1; addr = 5'd12; indata = 32'h0BADF00D;
        tick();
        check("wr_latency", outdata, 32'h0BADF00D);
        we = 1'b0;
        // addr changed after the edge does not redirect the committed write
        addr = 5'd13;
        #1;
        check("wr_addr_hold", outdata, 32'd13);

        // isolation
        for (int i = 0; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
        wr(5'd10, 32'h0);
        for (int i = 0; i < 32; i++)
            rd($sformatf("iso_%0d", i), 5'(i), (i == 10) ? 32'h0 : 32'(i) * 32'h01010101);

        // reset priority over a same-edge write
        reset = 1'b1; we = 1'b1; addr = 5'd5; indata = 32'hDEADBEEF;
        tick();
        reset = 1'b0; we = 1'b0;
        rd("rstpri_a5", 5'd5, 32'h0);
        rd("rstpri_a6", 5'd6, 32'h0);

        // unbacked addresses on the 20-word instance
        we20 = 1'b1; addr20 = 5'd5; indata20 = 32'h00000055;
        tick();
        we20 = 1'b1; addr20 = 5'd19; indata20 = 32'h00001919;
        tick();
        we20 = 1'b1; addr20 = 5'd25; indata20 = 32'h0000CAFE;
        tick();
        we20 = 1'b0;
        rd20("oor_a25", 5'd25, 32'h0);
        rd20("oor_a5", 5'd5, 32'h00000055);
        rd20("oor_a19", 5'd19, 32'h00001919);
        rd20("oor_a20", 5'd20, 32'h0);
        rd20("oor_a31", 5'd31, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
